// File: rtl/uart_line_echo_pkg.sv
// uart_line_echo_pkg: shared state encoding and ASCII constants for the line echo controller.
package uart_line_echo_pkg;

    typedef enum logic [1:0] {RX, TX_ISSUE, TX_WAIT_HI, TX_WAIT_LO} state_t;

    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] CASE_OFFSET   = 8'h20;

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z) ? b - CASE_OFFSET : b;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: DEPTH x 8 storage, synchronous write, combinational read.
module line_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_line_echo.sv
// uart_line_echo: buffers a received line, then replays it through uart_tx.
// Define UART_LINE_ECHO_UPPERCASE_EN to transmit a-z as A-Z.
module uart_line_echo
    import uart_line_echo_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] TERM_CHAR = ASCII_LF,
    parameter int         CNT_W     = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             tx_busy,
    output logic [7:0]       tx_data,
    output logic             tx_send,
    output logic             rx_ready,
    output logic             line_done,
    output logic [CNT_W-1:0] line_len,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_wr_ptr, r_rd_ptr, r_line_len;
    logic [7:0]       r_tx_data, r_drop_cnt, w_rd_byte, w_tx_byte;
    logic             r_tx_send, r_line_done, r_overflow;
    logic             w_wr_en, w_flush, w_issue, w_end, w_last, w_drop;

    line_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (rx_data),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_byte)
    );

`ifdef UART_LINE_ECHO_UPPERCASE_EN
    assign w_tx_byte = to_upper(w_rd_byte);
`else
    assign w_tx_byte = w_rd_byte;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= RX;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX:         w_next = w_flush ? TX_ISSUE : RX;
            TX_ISSUE:   w_next = w_issue ? TX_WAIT_HI : TX_ISSUE;
            TX_WAIT_HI: w_next = tx_busy ? TX_WAIT_LO : TX_WAIT_HI;
            default:    w_next = w_end ? (w_last ? RX : TX_ISSUE) : TX_WAIT_LO;
        endcase
    end

    // A line ends on the terminator or when the write fills the last entry.
    always_comb begin
        rx_ready = (r_state == RX);
        w_wr_en  = rx_ready && rx_valid;
        w_flush  = w_wr_en && (rx_data == TERM_CHAR || r_wr_ptr == CNT_W'(DEPTH-1));
        w_issue  = (r_state == TX_ISSUE) && !tx_busy && !r_tx_send;
        w_end    = (r_state == TX_WAIT_LO) && !tx_busy;
        w_last   = w_end && (r_rd_ptr >= r_line_len);
        w_drop   = rx_valid && !rx_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_line_len  <= '0;
            r_tx_data   <= '0;
            r_tx_send   <= 1'b0;
            r_line_done <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_tx_send   <= w_issue;
            r_line_done <= w_last;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_last) r_wr_ptr <= '0;
            if (w_flush) begin
                r_line_len <= r_wr_ptr + 1'b1;
                r_rd_ptr   <= '0;
            end
            if (w_flush && rx_data != TERM_CHAR) r_overflow <= 1'b1;
            if (w_issue) begin
                r_tx_data <= w_tx_byte;
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_send   = r_tx_send;
    assign line_done = r_line_done;
    assign line_len  = r_line_len;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_uart_line_echo.sv
// tb_uart_line_echo: randomized line echo bench with a queue-based reference model.
module tb_uart_line_echo;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset, rx_valid, tx_busy;
    logic [7:0] rx_data;
    logic [7:0] tx_data, drop_cnt;
    logic       tx_send, rx_ready, line_done, overflow;
    logic [4:0] line_len;

    int   checks = 0, errors = 0, viol = 0, ld_total = 0, ld_model = 0;
    int   drop_model = 0, drop_raw = 0;
    bit   ovf_model = 0;
    logic [7:0] q_tx[$];

    uart_line_echo dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .rx_ready  (rx_ready),
        .line_done (line_done),
        .line_len  (line_len),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xform(input logic [7:0] c);
`ifdef UART_LINE_ECHO_UPPERCASE_EN
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
        return c;
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Behavioural uart_tx: accept a byte, go busy after a short delay, then idle.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send) begin
                q_tx.push_back(tx_data);
                repeat ($urandom_range(1, 2)) @(negedge clk);
                tx_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    // Handshake rules: no back-to-back sends, no send while busy, data held between sends.
    initial begin
        bit prev_send, have;
        logic [7:0] last;
        prev_send = 0;
        have = 0;
        last = '0;
        forever begin
            @(negedge clk);
            if (tx_send && (prev_send || tx_busy)) viol++;
            if (!tx_send && have && !reset && tx_data !== last) viol++;
            if (tx_send) begin
                last = tx_data;
                have = 1;
            end
            if (reset) have = 0;
            prev_send = tx_send;
            if (line_done) ld_total++;
        end
    end

    task automatic send_bytes(input bq_t b);
        foreach (b[i]) begin
            @(negedge clk);
            rx_data  = b[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            if (i != b.size() - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // mode 0: quiet, 1: one 'X' during replay, 2: rx_valid on every non-RX cycle
    task automatic run_line(input bq_t b, input int mode, input string name);
        logic [7:0] exp_q[$];
        bit term, injected;
        int t;
        term = (b[b.size()-1] == 8'h0A);
        ovf_model = ovf_model | !term;
        foreach (b[i]) exp_q.push_back(xform(b[i]));
        q_tx.delete();
        send_bytes(b);
        injected = 0;
        for (t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (line_done) break;
            rx_valid = 1'b0;
            if (!rx_ready && (mode == 2 || (mode == 1 && !injected && tx_busy))) begin
                rx_data  = (mode == 1) ? 8'h58 : 8'($urandom);
                rx_valid = 1'b1;
                injected = 1;
                drop_raw++;
                if (drop_model < 255) drop_model++;
            end
        end
        rx_valid = 1'b0;
        ld_model++;
        checks++;
        if (t >= 3000) begin
            errors++;
            $display("FAIL %s line_done timeout: no pulse within 3000 cycles", name);
        end
        checks++;
        if (q_tx.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s echo_count: got %0d expected %0d", name, q_tx.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= q_tx.size() || q_tx[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s echo_byte[%0d]: got %h expected %h", name, i,
                         (i < q_tx.size()) ? q_tx[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (line_len !== 5'(b.size())) begin
            errors++;
            $display("FAIL %s line_len: got %0d expected %0d", name, line_len, b.size());
        end
        checks++;
        if (overflow !== ovf_model) begin
            errors++;
            $display("FAIL %s overflow: got %b expected %b", name, overflow, ovf_model);
        end
        checks++;
        if (drop_cnt !== 8'(drop_model)) begin
            errors++;
            $display("FAIL %s drop_cnt: got %0d expected %0d", name, drop_cnt, drop_model);
        end
    endtask

    function automatic bq_t rand_line(input int len, input bit allow_full);
        bq_t q;
        logic [7:0] c;
        for (int i = 0; i < len; i++) begin
            c = 8'($urandom);
            while (c == 8'h0A) c = 8'($urandom);
            q.push_back(c);
        end
        if (!(allow_full && len == 16)) q[len-1] = 8'h0A;
        return q;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_data, tx_send, rx_ready, line_done} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_tx: got data=%h send=%b ready=%b done=%b expected 00/0/1/0",
                     tx_data, tx_send, rx_ready, line_done);
        end
        checks++;
        if ({line_len, overflow, drop_cnt} !== {5'd0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_status: got len=%0d ovf=%b drop=%0d expected 0/0/0",
                     line_len, overflow, drop_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_normal();
        run_line(str2q("Hello World\n"), 0, "normal");
    endtask

    task automatic test_empty();
        run_line(str2q("\n"), 0, "empty");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) run_line(rand_line($urandom_range(1, 16), 1), 0, "random");
    endtask

    task automatic test_overflow();
        run_line(str2q("ABCDEFGHIJKLMNOP"), 0, "overflow_full");
        run_line(str2q("EF\n"), 0, "overflow_next");
        run_line(rand_line(16, 0), 0, "term_fills");
    endtask

    task automatic test_uppercase();
        run_line(str2q("ab1\n"), 0, "uppercase");
    endtask

    task automatic test_drop();
        run_line(str2q("QRSTUVW\n"), 1, "drop_one");
        for (int n = 0; n < 12 && drop_raw < 300; n++) run_line(rand_line(16, 0), 2, "drop_flood");
        checks++;
        if (drop_raw < 300) begin
            errors++;
            $display("FAIL drop_flood_volume: got %0d drops expected at least 300", drop_raw);
        end
    endtask

    task automatic test_reset_mid();
        int n, t;
        send_bytes(str2q("ABCDEFGHIJ\n"));
        n = 0;
        for (t = 0; t < 2000 && n < 3; t++) begin
            @(negedge clk);
            if (tx_send) n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL reset_mid_sends: got %0d sends expected 3", n);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_send, rx_ready, line_len, overflow, drop_cnt} !== {1'b0, 1'b1, 5'd0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_mid: got send=%b ready=%b len=%0d ovf=%b drop=%0d expected 0/1/0/0/0",
                     tx_send, rx_ready, line_len, overflow, drop_cnt);
        end
        reset = 1'b0;
        ovf_model = 0;
        drop_model = 0;
        for (t = 0; t < 100 && tx_busy; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        run_line(str2q("Hi\n"), 0, "after_reset");
    endtask

    task automatic test_protocol();
        repeat (2) @(negedge clk);
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL handshake: got %0d violations expected 0", viol);
        end
        checks++;
        if (ld_total !== ld_model) begin
            errors++;
            $display("FAIL line_done_count: got %0d expected %0d", ld_total, ld_model);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_empty();
        test_random();
        test_overflow();
        test_uppercase();
        test_drop();
        test_reset_mid();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
